// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// CAPACITY default matches the attached mem instance.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STREAK_W = 4;

  localparam logic [ADDR_W-1:0] DEFAULT_CAPACITY = 32'h0000_ffff;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // One accepted transaction, latched at grant time.
  typedef struct packed {
    owner_e              owner;
    logic                we;
    logic                err;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } txn_t;

  // Misaligned or beyond the last valid address.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] cap);
    return (addr[1:0] != 2'b00) || (addr > cap);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: DM priority, IF forced once the DM streak
// reaches its cap while IF is waiting.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic                if_req_i,
  input  logic                dm_req_i,
  input  logic                grant_window_i,
  input  logic [STREAK_W-1:0] dm_streak_i,
  output logic                if_gnt_c_o,
  output logic                dm_gnt_c_o
);

  logic if_forced;

  assign if_forced  = if_req_i && (dm_streak_i >= STREAK_W'(MAX_DM_STREAK));
  assign dm_gnt_c_o = grant_window_i && dm_req_i && !if_forced;
  assign if_gnt_c_o = grant_window_i && if_req_i && (!dm_req_i || if_forced);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported mem between instruction fetch and data memory.
// IDLE/RESP accept, ACCESS drives mem for one cycle, RESP returns the result.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CAPACITY      = DEFAULT_CAPACITY,
  parameter int unsigned       MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_memIn,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_memOut,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  txn_t                txn_q, txn_d, new_txn;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic                busy_q, busy_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_err_q, if_err_d;
  logic                dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                dm_err_q, dm_err_d;
  logic                grant_window;
  logic                accept;
  logic [DATA_W-1:0]   rdata_cap;

  assign grant_window = (state_q == IDLE) || (state_q == RESP);
  assign accept       = if_gnt || dm_gnt;

  mem_arb_pick #(
    .MAX_DM_STREAK (MAX_DM_STREAK)
  ) u_pick (
    .if_req_i       (if_req),
    .dm_req_i       (dm_req),
    .grant_window_i (grant_window),
    .dm_streak_i    (streak_q),
    .if_gnt_c_o     (if_gnt),
    .dm_gnt_c_o     (dm_gnt)
  );

  // Transaction that would be latched if a grant is taken this cycle.
  always_comb begin
    new_txn = '0;
    if (dm_gnt) begin
      new_txn.owner = OWN_DM;
      new_txn.we    = dm_we;
      new_txn.addr  = dm_addr;
      new_txn.wdata = dm_wdata;
      new_txn.err   = addr_err(dm_addr, CAPACITY);
    end else if (if_gnt) begin
      new_txn.owner = OWN_IF;
      new_txn.addr  = if_addr;
      new_txn.err   = addr_err(if_addr, CAPACITY);
    end
  end

  assign rdata_cap = (!txn_q.we && !txn_q.err) ? mem_memOut : '0;

  // Next-state, streak and response logic.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    txn_d       = txn_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    busy_d      = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = '0;
    if_err_d    = 1'b0;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = '0;
    dm_err_d    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d  = ACCESS;
          txn_d    = new_txn;
          mem_rd_d = !new_txn.we && !new_txn.err;
          mem_wr_d = new_txn.we && !new_txn.err;
          busy_d   = 1'b1;
          if (dm_gnt) begin
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q < STREAK_W'(MAX_DM_STREAK)) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end else begin
            streak_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (txn_q.owner == OWN_DM) begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = rdata_cap;
          dm_err_d    = txn_q.err;
        end else begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = rdata_cap;
          if_err_d    = txn_q.err;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      txn_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      txn_q       <= txn_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_err_q    <= dm_err_d;
    end
  end

  assign mem_address = txn_q.addr;
  assign mem_memIn   = txn_q.wdata;
  assign mem_read    = mem_rd_q;
  // Reset arriving during ACCESS must kill the store at that same edge.
  assign mem_write   = mem_wr_q && rst_n;
  assign busy        = busy_q;
  assign if_rvalid   = if_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign if_err      = if_err_q;
  assign dm_rvalid   = dm_rvalid_q;
  assign dm_rdata    = dm_rdata_q;
  assign dm_err      = dm_err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported `mem` instance between the instruction-fetch requester (read-only) and the data-memory requester (read/write).
- Replaces the separate insMem/DM instances in the planned multi-cycle yChip variant.
- Uses a 3-state FSM: accepts one transaction, drives the memory for one cycle, returns a registered response.
- Arbitration is fixed DM-priority with a starvation cap that guarantees IF forward progress.

Parameters:
- CAPACITY, 16'hffff: highest valid word address; must match the attached `mem` CAPACITY.
- MAX_DM_STREAK, 4: maximum consecutive DM grants while if_req is held before IF is forced to win. Legal range 1..15.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; if_addr held stable until granted
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  one-cycle fetch response strobe
- if_rdata  out  32  fetched word, valid with if_rvalid
- if_err  out  1  fetch address misaligned or > CAPACITY, valid with if_rvalid
- dm_req  in  1  data request; dm_we/dm_addr/dm_wdata held stable until granted
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_rvalid  out  1  one-cycle response strobe (load data or store ack)
- dm_rdata  out  32  load word; 0 for stores and errors
- dm_err  out  1  address error, valid with dm_rvalid
- mem_address  out  32  to mem address
- mem_memIn  out  32  to mem memIn
- mem_read  out  1  to mem read
- mem_write  out  1  to mem write
- mem_memOut  in  32  from mem memOut (combinational read)
- busy  out  1  high in ACCESS

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (rst_n low at posedge): state=IDLE; dm_streak=0; all response regs 0; all mem_* outputs 0.
- Grant window: gnt may assert only in IDLE or RESP, with at most one of if_gnt/dm_gnt per cycle.
- Accept: req & gnt at posedge latches owner, we, addr, wdata and err_flag (addr[1:0]!=0 or addr>CAPACITY), then state goes to ACCESS.
- Arbitration when both requests are high: DM wins unless dm_streak >= MAX_DM_STREAK, in which case IF wins. A single request always wins.
- dm_streak update:
  - On a DM grant with if_req high: increment, saturating at MAX_DM_STREAK.
  - On a DM grant with if_req low: clear to 0.
  - On an IF grant: clear to 0.
- ACCESS (exactly 1 cycle):
  - mem_address = latched addr.
  - mem_memIn = latched wdata.
  - mem_read = !we & !err_flag.
  - mem_write = we & !err_flag & rst_n. Gating with rst_n means a reset asserted during ACCESS suppresses the store.
  - At the posedge, capture rdata = mem_memOut when reading, else 0, then go to RESP.
- RESP (1 cycle):
  - Owner's rvalid = 1 with rdata/err; the other requester's rvalid/rdata/err stay 0.
  - mem_read = mem_write = 0.
  - Next state: ACCESS if a new request is accepted this cycle, else IDLE.
- Latency: accept at cycle N, memory access in N+1, response in N+2. Peak throughput is 1 transaction per 2 cycles.
- Outside RESP: all rvalid/rdata/err outputs are 0.
- Errors never touch memory. An errored store leaves memory unchanged; an errored load returns rdata=0, err=1.
- Reset mid-transaction drops the transaction with no response, and the FSM returns to IDLE.
- Requests deasserted before grant are legal and are simply not served.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - owner encoding (OWN_IF=0, OWN_DM=1)
  - default CAPACITY constant, shared with `mem`
- One natural sub-module, mem_arb_pick: purely combinational grant selection from if_req, dm_req, grant_window and dm_streak. Outputs if_gnt and dm_gnt.
- The FSM, streak counter and datapath registers live in the top module.

Test Plan:
1. Reset, then IF-only read at 0x10 where mem[0x10]=0xDEADBEEF -> if_gnt in cycle 0, busy=1 and mem_read=1 in cycle 1, if_rvalid=1 with if_rdata=0xDEADBEEF and if_err=0 in cycle 2.
2. DM store 0x12345678 to 0x20, then DM load 0x20 -> dm_rvalid ack with dm_rdata=0; load returns 0x12345678; mem_write high for exactly one cycle.
3. if_req and dm_req held high continuously, MAX_DM_STREAK=4 -> grant sequence DM,DM,DM,DM,IF,DM,DM,DM,DM,IF; no response is lost.
4. DM load at 0x22 and DM store at 0x20000 -> each gets dm_err=1 with dm_rdata=0; mem_read/mem_write never assert; memory contents unchanged.
5. Back-to-back IF requests -> gnt asserts in each RESP cycle; responses arrive every 2 cycles.
6. rst_n low during the ACCESS cycle of a store to 0x30 -> no dm_rvalid, mem[0x30] unchanged, outputs 0 and state IDLE after the edge.
